// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
// Optional feature macro used by this slice: MUX_TREE_SEL_CHECK_EN.
package mux_pkg;

    localparam int MAX_CHANNELS = 64;

    // ceil(log2(n)); saturates at the width needed for MAX_CHANNELS
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while (((1 << r) < n) && ((1 << r) < MAX_CHANNELS)) r++;
        return r;
    endfunction

    // Bit offset of level lvl's select slice inside the flattened select pipe.
    // Level lvl still carries sel_w - lvl bits, so offsets are a triangular sum.
    function automatic int sel_offset(input int sel_w, input int lvl);
        return lvl * sel_w - (lvl * (lvl - 1)) / 2;
    endfunction

    // Node index of the first input of level lvl in the flattened tree
    // (leaves first, then each level's registered outputs, root last).
    function automatic int node_offset(input int pad_n, input int lvl);
        return 2 * pad_n - 2 * (pad_n >> lvl);
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Stream interface of the pipelined mux tree: channel bus + select in,
// selected data out, valid/ready on both sides.
// sel_err exists only when MUX_TREE_SEL_CHECK_EN is defined.
interface mux_tree_pipe_if #(
    parameter int N_IN   = 16,
    parameter int DATA_W = 1
);
    import mux_pkg::*;

    localparam int SEL_W = clog2(N_IN);

    logic [N_IN*DATA_W-1:0] din;
    logic [SEL_W-1:0]       sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      out;
    logic                   out_valid;
    logic                   out_ready;

`ifdef MUX_TREE_SEL_CHECK_EN
    logic                   sel_err;

    modport master (
        output din, sel, in_valid, out_ready,
        input  in_ready, out, out_valid, sel_err
    );

    modport slave (
        input  din, sel, in_valid, out_ready,
        output in_ready, out, out_valid, sel_err
    );
`else
    modport master (
        output din, sel, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  din, sel, in_valid, out_ready,
        output in_ready, out, out_valid
    );
`endif

endinterface

// File: rtl/mux2_stage.sv
// One tree node: DATA_W-wide 2:1 select followed by its pipeline register.
// Data loads only with a valid beat so bubbles leave the register untouched.
module mux2_stage #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic              sel,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] q,
    output logic              q_valid
);

    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    // next state: hold while stalled, take a bubble or a selected beat otherwise
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = sel ? d1 : d0;
            end
        end
    end

    // node register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux built as a registered binary tree of mux2_stage nodes.
// Level L (0 = input side) selects with sel bit L; every level is registered,
// so latency is LEVELS = ceil(log2(N_IN)) cycles. The whole pipe stalls as one
// when the output holds a beat that downstream is not taking.
// Optional: MUX_TREE_SEL_CHECK_EN adds sel_err, flagging out-of-range selects.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int DATA_W = 1
) (
    input logic            clk,
    input logic            rst_n,
    mux_tree_pipe_if.slave bus
);

    localparam int SEL_W    = clog2(N_IN);
    localparam int LEVELS   = SEL_W;
    localparam int PAD_N    = 1 << SEL_W;
    localparam int NODES    = 2 * PAD_N - 1;
    localparam int SEL_BITS = sel_offset(SEL_W, LEVELS);

    // Flattened tree: leaves at [0, PAD_N), each level's outputs after, root last.
    logic [NODES*DATA_W-1:0] node_data;
    logic [NODES-1:0]        node_vld;
    // Select bits still needed by each level; level L's slice starts with bit L.
    logic [SEL_BITS-1:0]     sel_pipe;
    logic                    stage_en;

    // one global advance: the pipe moves unless a held output is being refused
    assign stage_en     = bus.out_ready | ~node_vld[NODES-1];
    assign bus.in_ready = stage_en;

    assign sel_pipe[SEL_W-1:0] = bus.sel;

`ifdef MUX_TREE_SEL_CHECK_EN
    localparam logic [SEL_W:0] N_IN_W = (SEL_W + 1)'(N_IN);

    logic [LEVELS:0] err_chain;

    assign err_chain[0] = ({1'b0, bus.sel} >= N_IN_W);
    assign bus.sel_err  = err_chain[LEVELS];
`endif

    // leaves: real channels, then zero padding up to the next power of two
    for (genvar k = 0; k < PAD_N; k++) begin : g_leaf
        if (k < N_IN) begin : g_chan
            assign node_data[k*DATA_W +: DATA_W] = bus.din[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign node_data[k*DATA_W +: DATA_W] = '0;
        end
        assign node_vld[k] = bus.in_valid;
    end

    for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_lvl
        localparam int IN_OFF  = node_offset(PAD_N, lvl);
        localparam int OUT_OFF = node_offset(PAD_N, lvl + 1);
        localparam int N_NODES = PAD_N >> (lvl + 1);
        localparam int S_OFF   = sel_offset(SEL_W, lvl);
        localparam int S_W     = SEL_W - lvl;

        for (genvar j = 0; j < N_NODES; j++) begin : g_node
            mux2_stage #(
                .DATA_W (DATA_W)
            ) u_node (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (stage_en),
                .in_valid (node_vld[IN_OFF+2*j] & node_vld[IN_OFF+2*j+1]),
                .sel      (sel_pipe[S_OFF]),
                .d0       (node_data[(IN_OFF+2*j)*DATA_W +: DATA_W]),
                .d1       (node_data[(IN_OFF+2*j+1)*DATA_W +: DATA_W]),
                .q        (node_data[(OUT_OFF+j)*DATA_W +: DATA_W]),
                .q_valid  (node_vld[OUT_OFF+j])
            );
        end

        if (S_W > 1) begin : g_sel
            logic [S_W-2:0] sel_rem_d, sel_rem_q;

            // carry the select bits the later levels still need
            always_comb begin
                sel_rem_d = sel_rem_q;
                if (stage_en) begin
                    sel_rem_d = sel_pipe[S_OFF+1 +: S_W-1];
                end
            end

            // select remainder register for the next level
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_rem_q <= '0;
                end else begin
                    sel_rem_q <= sel_rem_d;
                end
            end

            assign sel_pipe[S_OFF+S_W +: S_W-1] = sel_rem_q;
        end

`ifdef MUX_TREE_SEL_CHECK_EN
        logic err_d, err_q;

        // error flag rides with its beat and reads 0 on bubbles
        always_comb begin
            err_d = err_q;
            if (stage_en) begin
                err_d = node_vld[IN_OFF] & err_chain[lvl];
            end
        end

        // per-level error register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_d;
            end
        end

        assign err_chain[lvl+1] = err_q;
`endif
    end

    assign bus.out       = node_data[(NODES-1)*DATA_W +: DATA_W];
    assign bus.out_valid = node_vld[NODES-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: three instances (16x8, 10x8, 2x1),
// one exercised at a time against a queue-based reference model in which each
// accepted beat ages by one per non-stalled cycle and shows on out at age LEVELS.
// Honours MUX_TREE_SEL_CHECK_EN when defined.
module tb_mux_tree_pipe;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_tree_pipe_if #(.N_IN(16), .DATA_W(8)) bus16 ();
    mux_tree_pipe_if #(.N_IN(10), .DATA_W(8)) bus10 ();
    mux_tree_pipe_if #(.N_IN(2),  .DATA_W(1)) bus2 ();

    mux_tree_pipe #(.N_IN(16), .DATA_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    mux_tree_pipe #(.N_IN(10), .DATA_W(8)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));
    mux_tree_pipe #(.N_IN(2),  .DATA_W(1)) dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    logic [7:0] chan [64];

    typedef struct {
        logic [7:0] val;
        bit         err;
        int         age;
    } item_t;

    item_t      q[$];
    logic [7:0] last_out [3];

    function automatic int n_of(input int d);
        return (d == 0) ? 16 : (d == 1) ? 10 : 2;
    endfunction

    function automatic int lv_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int d = 0; d < 3; d++) last_out[d] = 8'h00;
    endtask

    task automatic drive(input bit iv, input int s, input bit ordy);
        for (int k = 0; k < 16; k++) bus16.din[k*8 +: 8] = chan[k];
        for (int k = 0; k < 10; k++) bus10.din[k*8 +: 8] = chan[k];
        for (int k = 0; k < 2; k++)  bus2.din[k] = chan[k][0];
        bus16.sel = 4'(s);
        bus10.sel = 4'(s);
        bus2.sel  = 1'(s);
        bus16.in_valid = (cur == 0) ? iv : 1'b0;
        bus10.in_valid = (cur == 1) ? iv : 1'b0;
        bus2.in_valid  = (cur == 2) ? iv : 1'b0;
        bus16.out_ready = (cur == 0) ? ordy : 1'b1;
        bus10.out_ready = (cur == 1) ? ordy : 1'b1;
        bus2.out_ready  = (cur == 2) ? ordy : 1'b1;
    endtask

    // {in_ready, out_valid, sel_err, out zero-extended to 8 bits}
    task automatic observe(output logic [10:0] obs);
        logic e16, e10, e2;
`ifdef MUX_TREE_SEL_CHECK_EN
        e16 = bus16.sel_err;
        e10 = bus10.sel_err;
        e2  = bus2.sel_err;
`else
        e16 = 1'b0;
        e10 = 1'b0;
        e2  = 1'b0;
`endif
        case (cur)
            0:       obs = {bus16.in_ready, bus16.out_valid, e16, bus16.out};
            1:       obs = {bus10.in_ready, bus10.out_valid, e10, bus10.out};
            default: obs = {bus2.in_ready, bus2.out_valid, e2, 7'b0, bus2.out};
        endcase
    endtask

    // Runs one clock of the active instance; entered and left at posedge+1.
    task automatic step(input bit iv, input int s, input bit ordy,
                        output logic [10:0] obs, output logic [10:0] exp);
        bit    vis, ir;
        item_t it;
        int    n;
        n = n_of(cur);
        drive(iv, s, ordy);
        #1;
        vis = (q.size() > 0) && (q[0].age == lv_of(cur));
        if (vis) last_out[cur] = q[0].val;
        ir  = ordy || !vis;
        exp = {ir, vis, (vis ? q[0].err : 1'b0), last_out[cur]};
        observe(obs);
        @(posedge clk);
        if (ir) begin
            if (vis) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (iv) begin
                it.val = (s < n) ? (chan[s] & ((cur == 2) ? 8'h01 : 8'hFF)) : 8'h00;
`ifdef MUX_TREE_SEL_CHECK_EN
                it.err = (s >= n);
`else
                it.err = 1'b0;
`endif
                it.age = 1;
                q.push_back(it);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 64; k++) chan[k] = 8'(k);
        #2;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            drive(1'b0, 0, 1'b0);
            #1;
            observe(o);
            checks++;
            if (o !== 11'h400) begin
                errors++;
                $display("FAIL reset_state dut=%0d got=%h want=%h", d, o, 11'h400);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            drive(1'b0, 0, 1'b0);
            #1;
            observe(o);
            checks++;
            if (o !== 11'h400) begin
                errors++;
                $display("FAIL reset_hold dut=%0d got=%h want=%h", d, o, 11'h400);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = 0;
    endtask

    task automatic test_sequential();
        logic [10:0] o, e;
        cur = 0;
        for (int k = 0; k < 16; k++) chan[k] = 8'(k * 3);
        for (int i = 0; i < 24; i++) begin
            step(i < 16, i, 1'b1, o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sequential cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [10:0] o, e;
        cur = 0;
        for (int k = 0; k < 16; k++) chan[k] = 8'($urandom);
        for (int i = 0; i < 17; i++) begin
            step((i < 9), $urandom_range(0, 15), !(i >= 4 && i < 9), o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [10:0] o, e;
        int sels [8] = '{12, 3, 15, 9, 10, 0, 11, 12};
        cur = 1;
        for (int k = 0; k < 16; k++) chan[k] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 16; i++) begin
            step(i < 8, (i < 8) ? sels[i] : 0, 1'b1, o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL out_of_range cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_alternating();
        logic [10:0] o, e;
        cur = 0;
        for (int k = 0; k < 16; k++) chan[k] = 8'($urandom);
        for (int i = 0; i < 22; i++) begin
            step((i < 16) && (i % 2 == 0), $urandom_range(0, 15), 1'b1, o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alternating cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [10:0] o, e;
        cur = 0;
        for (int k = 0; k < 16; k++) chan[k] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom_range(0, 9), 1'b1, o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_reset_fill cyc=%0d got=%h want=%h", i, o, e);
            end
        end
        drive(1'b0, 0, 1'b0);
        #1;
        observe(o);
        checks++;
        if (o[9] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre_valid got=%b want=1", o[9]);
        end
        rst_n = 1'b0;
        #1;
        observe(o);
        checks++;
        if (o !== 11'h400) begin
            errors++;
            $display("FAIL mid_reset_drop got=%h want=%h", o, 11'h400);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step((i >= 3 && i < 6), $urandom_range(0, 15), 1'b1, o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_reset_after cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_two_input();
        logic [10:0] o, e;
        logic [2:0]  c;
        cur = 2;
        for (int i = 0; i < 12; i++) begin
            c = 3'(i);
            chan[0] = {7'b0, c[0]};
            chan[1] = {7'b0, c[1]};
            step(i < 8, int'(c[2]), 1'b1, o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL two_input cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_random_stall();
        logic [10:0] o, e;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int i = 0; i < 310; i++) begin
                for (int k = 0; k < 16; k++) chan[k] = 8'($urandom);
                step((i < 300) && ($urandom_range(0, 3) != 0),
                     $urandom_range(0, (d == 2) ? 1 : 15),
                     (i >= 300) || ($urandom_range(0, 2) != 0), o, e);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random dut=%0d cyc=%0d got=%h want=%h", d, i, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_out_of_range();
        test_alternating();
        test_mid_reset();
        test_two_input();
        test_random_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
